// File: rtl/cp0_int_ctrl_pkg.sv
// cp0_int_ctrl_pkg: CP0 register numbers, SR/Cause field positions and ExcCodes
package cp0_int_ctrl_pkg;
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;
  localparam int SR_IM_LO  = 10;
  localparam int SR_EXL    = 1;
  localparam int SR_IE     = 0;
  localparam int CAUSE_BD  = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
endpackage

// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: CP0 interrupt/exception controller with SR, Cause, EPC and PRId
module cp0_int_ctrl
  import cp0_int_ctrl_pkg::*;
#(
  parameter int HW_INT_W = 6,
  parameter logic [31:0] PRID_VAL = 32'h0000_4350
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          addr,
  input  logic [31:0]         data_in,
  input  logic                we,
  output logic [31:0]         data_out,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                exc_req,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         pc_in,
  input  logic                bd_in,
  input  logic                eret,
  output logic                take,
  output logic [31:0]         epc_out
);
  logic [HW_INT_W-1:0] im_q, im_d, ip_q, ip_d;
  logic                exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]          exc_q, exc_d;
  logic [31:0]         epc_q, epc_d;
  logic                int_req, exc_ok, wr_sr, wr_epc;
  logic [31:0]         sr, cause;
  always_comb begin
    int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
    exc_ok  = exc_req & ~exl_q;
    take    = int_req | exc_ok;
    // a write from an instruction being flushed by take is dropped
    wr_sr   = we & ~take & (addr == CP0_SR);
    wr_epc  = we & ~take & (addr == CP0_EPC);
    im_d    = wr_sr ? data_in[SR_IM_LO +: HW_INT_W] : im_q;
    ie_d    = wr_sr ? data_in[SR_IE] : ie_q;
    exl_d   = take ? 1'b1 : eret ? 1'b0 : wr_sr ? data_in[SR_EXL] : exl_q;
    bd_d    = take ? bd_in : bd_q;
    exc_d   = take ? (int_req ? EXC_INT : exc_code) : exc_q;
    epc_d   = take ? ((bd_in ? pc_in - 32'd4 : pc_in) & 32'hFFFF_FFFC)
            : wr_epc ? (data_in & 32'hFFFF_FFFC) : epc_q;
    ip_d    = hw_int;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      ip_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ip_q  <= ip_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end
  always_comb begin
    sr = '0;
    sr[SR_IM_LO +: HW_INT_W] = im_q;
    sr[SR_EXL] = exl_q;
    sr[SR_IE]  = ie_q;
    cause = '0;
    cause[CAUSE_BD] = bd_q;
    cause[CAUSE_IP_LO +: HW_INT_W] = ip_q;
    cause[CAUSE_EXC_LO +: 5] = exc_q;
    data_out = addr == CP0_SR ? sr : addr == CP0_CAUSE ? cause
             : addr == CP0_EPC ? epc_q : addr == CP0_PRID ? PRID_VAL : '0;
  end
  assign epc_out = epc_q;
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb_cp0_int_ctrl: directed stimulus checked against a word-level CP0 model every cycle
module tb_cp0_int_ctrl;
  logic        clk = 0, reset = 0, we = 0, exc_req = 0, bd_in = 0, eret = 0;
  logic [4:0]  addr = 0, exc_code = 0;
  logic [31:0] data_in = 0, pc_in = 0;
  logic [5:0]  hw_int = 0;
  logic [31:0] data_out, epc_out;
  logic        take;
  int checks = 0, failures = 0;
  logic [31:0] m_sr = 0, m_cause = 0, m_epc = 0;

  cp0_int_ctrl dut (.clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we),
    .data_out(data_out), .hw_int(hw_int), .exc_req(exc_req), .exc_code(exc_code),
    .pc_in(pc_in), .bd_in(bd_in), .eret(eret), .take(take), .epc_out(epc_out));

  always #5 clk = ~clk;

  function automatic logic m_int();
    return ((m_cause & m_sr & 32'h0000_FC00) != 0) && m_sr[0] && !m_sr[1];
  endfunction
  function automatic logic m_take();
    return m_int() || (exc_req && !m_sr[1]);
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    return a == 12 ? m_sr : a == 13 ? m_cause : a == 14 ? m_epc : a == 15 ? 32'h0000_4350 : 32'h0;
  endfunction
  function automatic logic [31:0] nxt_sr();
    logic [31:0] s;
    s = m_take() ? (m_sr | 32'h2) : (we && addr == 12) ? (data_in & 32'h0000_FC03) : m_sr;
    return (eret && !m_take()) ? (s & ~32'h2) : s;
  endfunction
  function automatic logic [31:0] nxt_epc();
    return m_take() ? ((bd_in ? pc_in - 32'd4 : pc_in) & ~32'h3)
         : (we && addr == 14) ? (data_in & ~32'h3) : m_epc;
  endfunction
  function automatic logic [31:0] nxt_cause();
    logic [31:0] c;
    c = m_take() ? ({bd_in, 31'd0} | (m_int() ? 32'd0 : {25'd0, exc_code, 2'b00}))
      : (m_cause & 32'h8000_007C);
    return c | {16'd0, hw_int, 10'd0};
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_sr <= 0; m_cause <= 0; m_epc <= 0;
    end else begin
      m_sr <= nxt_sr(); m_cause <= nxt_cause(); m_epc <= nxt_epc();
    end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk)
    if (reset) begin
      chk("model_take", {31'd0, take}, {31'd0, m_take()});
      chk("model_epc_out", epc_out, m_epc);
      chk("model_data_out", data_out, m_read(addr));
    end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic rd(input string n, input logic [4:0] a, input logic [31:0] e);
    addr = a; #1; chk(n, data_out, e);
  endtask

  initial begin
    #3;
    rd("rst_sr", 12, 0);
    rd("rst_prid", 15, 32'h0000_4350);
    chk("rst_take", {31'd0, take}, 0);
    #19 reset = 1;
    tick();
    // 1: interrupt taken one cycle after the line rises
    addr = 12; data_in = 32'h0000_0401; we = 1; tick(); we = 0;
    hw_int = 6'h01; pc_in = 32'h3010; bd_in = 0; tick();
    chk("t1_take", {31'd0, take}, 1);
    tick(); hw_int = 0;
    rd("t1_sr", 12, 32'h0000_0403);
    rd("t1_epc", 14, 32'h0000_3010);
    rd("t1_cause", 13, 32'h0000_0400);
    // 2: overflow in a delay slot
    eret = 1; tick(); eret = 0;
    bd_in = 1; pc_in = 32'h3020; exc_req = 1; exc_code = 12; #1;
    chk("t2_take", {31'd0, take}, 1);
    tick(); exc_req = 0; bd_in = 0;
    rd("t2_epc", 14, 32'h0000_301C);
    rd("t2_cause", 13, 32'h8000_0030);
    // 3: interrupt wins over a simultaneous exception, then eret
    eret = 1; tick(); eret = 0;
    hw_int = 6'h01; tick();
    exc_req = 1; exc_code = 4; pc_in = 32'h3040; #1;
    chk("t3_take", {31'd0, take}, 1);
    tick(); exc_req = 0; hw_int = 0;
    rd("t3_cause", 13, 32'h0000_0400);
    eret = 1; tick(); eret = 0;
    rd("t3_sr", 12, 32'h0000_0401);
    chk("t3_idle", {31'd0, take}, 0);
    tick();
    chk("t3_idle2", {31'd0, take}, 0);
    // 4: nested requests suppressed while EXL is set
    exc_req = 1; exc_code = 10; pc_in = 32'h3050; tick();
    hw_int = 6'h03; exc_code = 5; pc_in = 32'h3060;
    for (int i = 0; i < 5; i++) begin
      chk("t4_take", {31'd0, take}, 0);
      tick();
    end
    exc_req = 0;
    rd("t4_epc", 14, 32'h0000_3050);
    rd("t4_cause", 13, 32'h0000_0C28);
    hw_int = 0; tick();
    // 5: mtc0 EPC dropped under take, standalone write masks low bits
    eret = 1; tick(); eret = 0;
    exc_req = 1; exc_code = 12; pc_in = 32'h4000; we = 1; addr = 14; data_in = 32'h1235; #1;
    chk("t5_take", {31'd0, take}, 1);
    tick(); we = 0; exc_req = 0;
    rd("t5_epc", 14, 32'h0000_4000);
    we = 1; data_in = 32'h1237; tick(); we = 0;
    rd("t5_epc2", 14, 32'h0000_1234);
    // 6: asynchronous reset mid-handler
    #1 reset = 0;
    rd("t6_sr", 12, 0);
    rd("t6_cause", 13, 0);
    rd("t6_epc", 14, 0);
    rd("t6_prid", 15, 32'h0000_4350);
    rd("t6_addr7", 7, 0);
    chk("t6_take", {31'd0, take}, 0);
    chk("t6_epc_out", epc_out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
CPU-side receiver for the peripheral Interrupt lines: a coprocessor-0 style controller that sits in the pipeline's M stage.
- Registers the hardware interrupt lines from the timers and other devices, masks them against SR, and arbitrates them against synchronous exceptions.
- Issues a single take pulse to the pipeline and captures EPC, Cause and the branch-delay flag.
- Serves mtc0/mfc0 accesses to SR, Cause, EPC and PRId, and clears EXL on eret.

Parameters:
HW_INT_W, 6, number of hardware interrupt lines (maps to SR/Cause bits [15:10])
PRID_VAL, 32'h0000_4350, read-only PRId contents

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous reset, active-low; asserted = 0
addr  in  5  CP0 register number (rd field): 12 SR, 13 Cause, 14 EPC, 15 PRId
data_in  in  32  mtc0 write data
we  in  1  mtc0 write strobe
data_out  out  32  mfc0 read data, combinational on addr
hw_int  in  HW_INT_W  level interrupt lines from devices
exc_req  in  1  synchronous exception present in M stage
exc_code  in  5  ExcCode of that exception
pc_in  in  32  PC of the M-stage instruction
bd_in  in  1  M-stage instruction sits in a branch delay slot
eret  in  1  eret in M stage
take  out  1  combinational; pipeline flushes and redirects to handler
epc_out  out  32  current EPC, for the eret redirect

Behaviour:
- Reset (reset == 0, asynchronous): SR = 0, Cause = 0, EPC = 0, ip_q = 0.
  - Therefore take = 0 and data_out is 0 except for PRId.
- SR fields:
  - IM = SR[15:10], EXL = SR[1], IE = SR[0].
  - All other bits read 0 and ignore writes.
- Cause fields:
  - BD = Cause[31], IP = Cause[15:10], ExcCode = Cause[6:2].
  - All other bits read 0.
  - Cause is not writable by mtc0.
- EPC: 32 bits; bits [1:0] are forced to 0 on every write path.
- IP sampling:
  - ip_q <= hw_int every cycle, unconditionally; one cycle of latency from a device's Interrupt to IP.
  - IP mirrors ip_q.
  - IP is level-sensitive: a device must hold its line until it is serviced. A pulse that drops before it is taken is lost (legal).
- Request logic (combinational):
  - int_req = (|(ip_q & IM)) & IE & ~EXL
  - exc_ok = exc_req & ~EXL
  - take = int_req | exc_ok
- Priority: interrupt beats exception.
  - If both are present, ExcCode = 0.
  - Otherwise ExcCode = exc_code.
- On a take cycle (registered at the clock edge):
  - EXL <= 1
  - BD <= bd_in
  - EPC <= bd_in ? pc_in - 4 : pc_in, with low bits cleared
  - ExcCode updated as above
  - IM, IE and IP are unaffected.
- eret: EXL <= 0. Because EXL = 1 in that cycle, take is 0, so the two never coincide.
- mtc0 (we = 1, no take):
  - addr 12 writes IM/EXL/IE.
  - addr 14 writes EPC.
  - Other addresses are ignored.
- mtc0 coinciding with take: the write is dropped entirely; the pipeline is flushing that instruction.
- mtc0 to SR coinciding with eret: eret applies to EXL; the write applies to IM/IE only.
- Read: addr 12, 13, 14 and 15 return SR, Cause, EPC and PRID_VAL respectively. Any other address reads 0.
  - A read in the same cycle as a write returns the old value.
- Nested exceptions while EXL = 1 are suppressed; take stays low and exc_req is ignored.
- epc_out = EPC register value, continuously.

Decomposition:
- Shared package:
  - CP0 register numbers (12–15)
  - SR/Cause bit positions (IM_LO = 10, EXL = 1, IE = 0, BD = 31, EXC_LO = 2)
  - ExcCode constants: INT = 0, ADEL = 4, ADES = 5, RI = 10, OV = 12
- No sub-module; a single flat block. The request logic is small enough to stay inline.

Test Plan:
1. Reset, then write SR = 32'h0000_0401 (IM[10] set, IE set). Raise hw_int[0] = 1 with pc_in = 32'h0000_3010, bd_in = 0.
   - Cycle+1: take = 1.
   - After the edge: EXL = 1, EPC = 32'h3010, Cause = 32'h0000_0400.
2. With bd_in = 1 and pc_in = 32'h3020, raise exc_req with exc_code = 12 and no interrupt pending.
   - take = 1.
   - After the edge: EPC = 32'h301C, Cause = 32'h8000_0030.
3. Raise exc_req (code 4) and a masked-in hw_int in the same cycle.
   - ExcCode = 0 (interrupt wins).
   - Then issue eret: EXL = 0, take stays 0 while hw_int is low.
4. With EXL = 1, raise hw_int and exc_req for 5 cycles.
   - take = 0 throughout; EPC and Cause.ExcCode are unchanged.
   - Cause.IP still tracks hw_int.
5. Issue mtc0 addr 14 data 32'h1235 in the same cycle as take.
   - EPC holds the take value, not 32'h1234.
   - A standalone write of 32'h1237 reads back 32'h1234.
6. Drop reset to 0 mid-handler (EXL = 1, asynchronous, between edges).
   - SR, Cause and EPC read 0 immediately; addr 15 reads PRID_VAL; addr 7 reads 0.
